// File: rtl/e_calc_pkg.sv
// Shared constants and state encoding for the e-series calculator and its digit streamer.
// Defining E_DIGIT_ASCII_EN switches emitted characters from raw BCD to ASCII.
package e_calc_pkg;

   localparam int WIDTH     = 400;
   localparam int INT_BITS  = 8;
   localparam int FRAC_BITS = WIDTH - INT_BITS;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_DOT  = 8'h2E;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_INT  = 3'd1,
      ST_DOT  = 3'd2,
      ST_MUL  = 3'd3,
      ST_FRAC = 3'd4,
      ST_FIN  = 3'd5
   } tx_state_t;

   function automatic logic [7:0] digit_char(input logic [3:0] bcd);
`ifdef E_DIGIT_ASCII_EN
      return ASCII_ZERO | {4'h0, bcd};
`else
      return {4'h0, bcd};
`endif
   endfunction

endpackage

// File: rtl/e_digit_tx_if.sv
// Character stream from the digit streamer to the display/UART consumer.
interface e_digit_tx_if;

   // A character moves when digit_valid and digit_ready are both high at a rising
   // edge; once raised, digit_valid stays high and digit/digit_is_int stay frozen
   // until that transfer happens. digit_valid never depends on digit_ready.
   logic       digit_valid;
   logic       digit_ready;
   logic [7:0] digit;
   logic       digit_is_int;

   modport master (
      output digit_valid,
      output digit,
      output digit_is_int,
      input  digit_ready
   );

   modport slave (
      input  digit_valid,
      input  digit,
      input  digit_is_int,
      output digit_ready
   );

endinterface

// File: rtl/e_digit_tx_mul10_frac.sv
// Multiplies a binary fraction by ten: the overflow nibble is the next decimal digit.
module mul10_frac
   import e_calc_pkg::*;
#(
   parameter int FRAC_W = FRAC_BITS
) (
   input  logic [FRAC_W-1:0] i_frac,
   output logic [FRAC_W-1:0] o_frac,
   output logic [3:0]        o_digit
);

   logic [FRAC_W+3:0] w_ext;
   logic [FRAC_W+3:0] w_prod;

   // x*10 as x*8 + x*2; the product of a pure fraction never exceeds 9.x
   assign w_ext   = {4'b0000, i_frac};
   assign w_prod  = (w_ext << 3) + (w_ext << 1);
   assign o_frac  = w_prod[FRAC_W-1:0];
   assign o_digit = w_prod[FRAC_W+3:FRAC_W];

endmodule

// File: rtl/e_digit_tx.sv
// Streams a fixed-point value as one integer digit plus NUM_DIGITS fractional digits.
// E_DIGIT_ASCII_EN: emit ASCII characters and a '.' after the integer digit.
module e_digit_tx
   import e_calc_pkg::*;
#(
   parameter int NUM_DIGITS = 100
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [WIDTH-1:0]  i_value,
   e_digit_tx_if.master      tx,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output tx_state_t         o_state
);

   localparam int CNT_W = $clog2(NUM_DIGITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

   tx_state_t             r_state;
   tx_state_t             w_next;
   logic [INT_BITS-1:0]   r_ip;
   logic [FRAC_BITS-1:0]  r_frac;
   logic [3:0]            r_d;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_err;

   logic                  w_valid;
   logic                  w_is_int;
   logic                  w_dot;
   logic [3:0]            w_bcd;
   logic [7:0]            w_digit;
   logic                  w_xfer;
   logic                  w_ip_ovf;
   logic                  w_last;
   logic [FRAC_BITS-1:0]  w_mul_frac;
   logic [3:0]            w_mul_digit;

   mul10_frac #(
      .FRAC_W (FRAC_BITS)
   ) u_mul10 (
      .i_frac  (r_frac),
      .o_frac  (w_mul_frac),
      .o_digit (w_mul_digit)
   );

   assign w_ip_ovf = (r_ip > INT_BITS'(9));
   assign w_last   = (r_cnt == LAST_CNT);
   assign w_xfer   = w_valid & tx.digit_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_valid  = 1'b0;
      w_is_int = 1'b0;
      w_dot    = 1'b0;
      w_bcd    = 4'd0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_next = ST_INT;
            end
         end
         ST_INT: begin
            w_valid  = 1'b1;
            w_is_int = 1'b1;
            // an integer part above 9 cannot be shown; clamp and flag it
            w_bcd    = w_ip_ovf ? 4'd9 : r_ip[3:0];
            if (tx.digit_ready) begin
`ifdef E_DIGIT_ASCII_EN
               w_next = ST_DOT;
`else
               w_next = ST_MUL;
`endif
            end
         end
`ifdef E_DIGIT_ASCII_EN
         ST_DOT: begin
            w_valid = 1'b1;
            w_dot   = 1'b1;
            if (tx.digit_ready) begin
               w_next = ST_MUL;
            end
         end
`endif
         ST_MUL: begin
            w_next = ST_FRAC;
         end
         ST_FRAC: begin
            w_valid = 1'b1;
            w_bcd   = r_d;
            if (tx.digit_ready) begin
               w_next = w_last ? ST_FIN : ST_MUL;
            end
         end
         ST_FIN: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_digit = 8'h00;
      if (w_dot) begin
         w_digit = ASCII_DOT;
      end else if (w_valid) begin
         w_digit = digit_char(w_bcd);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ip   <= '0;
         r_frac <= '0;
         r_d    <= 4'd0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_ip   <= i_value[WIDTH-1:FRAC_BITS];
                  r_frac <= i_value[FRAC_BITS-1:0];
                  r_cnt  <= '0;
                  r_done <= 1'b0;
                  r_err  <= 1'b0;
                  r_busy <= 1'b1;
               end
            end
            ST_INT: begin
               if (w_ip_ovf) begin
                  r_err <= 1'b1;
               end
            end
            ST_MUL: begin
               r_d    <= w_mul_digit;
               r_frac <= w_mul_frac;
            end
            ST_FRAC: begin
               // counter stops at the last index, so it never wraps
               if (w_xfer && !w_last) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_FIN: begin
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign tx.digit_valid  = w_valid;
   assign tx.digit        = w_digit;
   assign tx.digit_is_int = w_is_int;
   assign o_busy          = r_busy;
   assign o_done          = r_done;
   assign o_err           = r_err;
   assign o_state         = r_state;

endmodule

// File: doc/e_digit_tx.md
# e_digit_tx

Streams the 400-bit fixed-point result of the e series calculator out as decimal digits, one per valid/ready handshake. Digits are produced by repeated multiply-by-10 of the fractional part. The block sits between the calculator's `ans`/`done` outputs and the board's display or UART path, which is the consumer.

## Interface
- `WIDTH`, 400, total input width.
- `INT_BITS`, 8, integer bits at the MSB end; fractional bits are `FRAC_BITS = WIDTH-INT_BITS` (392).
- `NUM_DIGITS`, 100, fractional digits emitted; legal range 1..118.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request conversion of `value`; sampled only in IDLE.
- `value`  in  WIDTH  unsigned fixed-point operand; sampled on the accepted `start`.
- `digit_valid`  out  1  `digit` holds a character.
- `digit_ready`  in  1  consumer accepts the character.
- `digit`  out  8  BCD in bits [3:0] with [7:4]=0, or ASCII when the macro is defined.
- `digit_is_int`  out  1  the current character is the integer digit.
- `busy`  out  1  conversion in progress.
- `done`  out  1  last digit accepted; held until the next accepted `start` or `rst`.
- `err`  out  1  integer part exceeded 9; sticky until the next accepted `start`.

## Operation
- States: IDLE, INT, DOT (present only with the macro), MUL, FRAC, FIN.
- IDLE, when `start`=1:
  - `ip`←`value[WIDTH-1:FRAC_BITS]`, `frac`←`value[FRAC_BITS-1:0]`, `cnt`←0.
  - `done`←0, `err`←0, `busy`←1.
  - Next state: INT.
- INT:
  - `digit_valid`=1, `digit_is_int`=1.
  - `digit` = `ip` if `ip`≤9. Otherwise `digit` = 9 and `err`←1.
  - On handshake go to DOT (macro defined) or MUL.
- DOT: `digit_valid`=1, `digit`=0x2E. On handshake go to MUL.
- MUL (single cycle, no output):
  - `p` = `frac`×10 as (FRAC_BITS+4) bits.
  - `d`←`p[FRAC_BITS+3:FRAC_BITS]`, which is always ≤9.
  - `frac`←`p[FRAC_BITS-1:0]`.
  - Next state: FRAC.
- FRAC:
  - `digit_valid`=1, `digit`=`d`.
  - On handshake: if `cnt`==NUM_DIGITS-1 go to FIN, else `cnt`←`cnt`+1 and go to MUL.
- FIN: `done`←1, `busy`←0, go to IDLE.
- Handshake rules:
  - Transfer occurs when `digit_valid`&`digit_ready` at a rising edge.
  - While `digit_valid`=1 and `digit_ready`=0, `digit` and `digit_is_int` hold stable.
  - `digit_valid` never drops without a transfer.
- `start` while `busy`=1 is ignored, and `value` is not re-sampled.
- `start`=1 in the same cycle the state returns from FIN to IDLE is not seen; it is accepted the cycle after.
- Reset values: `digit_valid`=0, `digit`=0, `digit_is_int`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Reset mid-stream: the in-flight character is dropped and no partial `done` is issued.
- `value`=0 emits 0 followed by NUM_DIGITS zeros.
- `cnt` is `$clog2(NUM_DIGITS+1)` bits wide and never wraps.

## Timing
- `start` accepted at edge N → `busy`=1 and `digit_valid`=1 (integer digit) after edge N.
- With `digit_ready` held at 1:
  - one character per cycle in INT and DOT;
  - one fractional digit every 2 cycles (MUL bubble).
- Total cycles from `start` to `done`: 1 + 1(+1 DOT) + 2·NUM_DIGITS + 1 (FIN).
- `done` is asserted the edge after FIN is entered.
- The ×10 is shift-add (`frac`<<3 + `frac`<<1) and must close timing in one cycle.

## Configuration
- `E_DIGIT_ASCII_EN` defined:
  - `digit` = 0x30+BCD.
  - DOT state is present, so '.' (0x2E) is emitted after the integer digit.
  - Total output is NUM_DIGITS+2 characters.
- Undefined:
  - `digit` is raw BCD, zero-extended.
  - DOT state is absent; total output is NUM_DIGITS+1 characters.

## Structure
- Shared package `e_calc_pkg` holds:
  - WIDTH=400 and INT_BITS=8, common with the calculator;
  - the state encoding;
  - ASCII constants 0x30 and 0x2E.
- One combinational sub-module, `mul10_frac`: input `frac`, outputs next `frac` and the 4-bit digit. Keeping it separate lets it be unit-tested in isolation.

## Test plan
- `value` = 2.5 (`ip`=2, `frac` MSB only), NUM_DIGITS=3, ready=1, macro off → digits 2,5,0,0; `digit_is_int`=1 only on the first; `done` after 9 cycles.
- `value` = 400-bit e constant from the calculator, macro on → 0x32,0x2E,0x37,0x31,0x38,0x32,0x38,0x31,… with the first 100 fractional digits matching the known expansion.
- Backpressure: `digit_ready` low for 5 cycles mid-stream → `digit`/`digit_valid` held constant; no digit lost or duplicated.
- `ip`=12 → `err`=1, first digit 9, remaining digits correct; next `start` clears `err`.
- `start` pulsed while `busy` with a different `value` → ignored; output unchanged.
- `rst` asserted after the 4th fractional digit → next edge all outputs 0 and state IDLE; a fresh `start` restarts from the integer digit.
